// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the 16-bit multi-cycle core
//
// Holds the datapath width, the next-PC selection encodings used by the
// fetch stage, decode stage and control unit, and the fetch FSM state type.
package cpu_pkg;

    parameter int DATA_W = 16;

    // Next-PC selection (PCsrc) encodings.
    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RET    = 2'b11;

    typedef enum logic [0:0] {
        IF_IDLE = 1'b0,
        IF_WAIT = 1'b1
    } if_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - combinational next-PC selection including the PC+1 adder
//
// Ports:
//   pc_i           current program counter
//   pc_src_i       selection: PC_INC, PC_BRANCH, PC_JUMP, PC_RET
//   b_target_i     branch target
//   jump_target_i  jump target
//   return_addr_i  return address
//   next_pc_o      selected next PC
module pc_next_mux
    import cpu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] pc_i,
    input  logic [1:0]   pc_src_i,
    input  logic [W-1:0] b_target_i,
    input  logic [W-1:0] jump_target_i,
    input  logic [W-1:0] return_addr_i,
    output logic [W-1:0] next_pc_o
);

    logic [W-1:0] pc_inc;

    // Word addressing: the increment wraps modulo 2^W.
    assign pc_inc = pc_i + {{(W-1){1'b0}}, 1'b1};

    always_comb begin
        next_pc_o = pc_inc;
        case (pc_src_i)
            PC_INC:    next_pc_o = pc_inc;
            PC_BRANCH: next_pc_o = b_target_i;
            PC_JUMP:   next_pc_o = jump_target_i;
            PC_RET:    next_pc_o = return_addr_i;
            default:   next_pc_o = pc_inc;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC ownership and req/ack fetch FSM
//
// Ports:
//   clk, reset                     clock, async active-high reset
//   enable_IF                      one-cycle fetch request from control
//   pc_update, PCsrc               one-cycle PC load and its selection
//   BTarget, jumpTarget, returnAddr candidate next PCs
//   imem_req, imem_addr            request and address to instruction memory
//   imem_rdata, imem_ack           returned word and completion from memory
//   instruction, nextPC            last fetched word and its address plus 1
//   PC                             current program counter
//   fetch_done                     one-cycle pulse when instruction/nextPC update
//   busy                           fetch outstanding
//   pc_err                         sticky protocol-error flag
module if_stage #(
    parameter int                 DATA_W   = cpu_pkg::DATA_W,
    parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_IF,
    input  logic              pc_update,
    input  logic [1:0]        PCsrc,
    input  logic [DATA_W-1:0] BTarget,
    input  logic [DATA_W-1:0] jumpTarget,
    input  logic [DATA_W-1:0] returnAddr,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_ack,
    output logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] nextPC,
    output logic [DATA_W-1:0] PC,
    output logic              fetch_done,
    output logic              busy,
    output logic              pc_err
);

    import cpu_pkg::*;

    if_state_e         state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] next_pc_q, next_pc_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] sel_pc;

    pc_next_mux #(
        .W (DATA_W)
    ) u_pc_next_mux (
        .pc_i          (pc_q),
        .pc_src_i      (PCsrc),
        .b_target_i    (BTarget),
        .jump_target_i (jumpTarget),
        .return_addr_i (returnAddr),
        .next_pc_o     (sel_pc)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        next_pc_d = next_pc_q;
        addr_d    = addr_q;
        req_d     = req_q;
        done_d    = 1'b0;
        err_d     = err_q;

        case (state_q)
            IF_IDLE: begin
                // A stray ack while idle is simply dropped.
                if (pc_update) begin
                    pc_d = sel_pc;
                end
                if (enable_IF) begin
                    // A PC load in the same cycle redirects this fetch.
                    addr_d  = pc_update ? sel_pc : pc_q;
                    req_d   = 1'b1;
                    state_d = IF_WAIT;
                end
            end
            IF_WAIT: begin
                if (pc_update || enable_IF) begin
                    err_d = 1'b1;
                end
                if (imem_ack) begin
                    instr_d   = imem_rdata;
                    next_pc_d = addr_q + {{(DATA_W-1){1'b0}}, 1'b1};
                    done_d    = 1'b1;
                    req_d     = 1'b0;
                    state_d   = IF_IDLE;
                end
            end
            default: begin
                state_d = IF_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IF_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            next_pc_q <= '0;
            addr_q    <= RESET_PC;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            next_pc_q <= next_pc_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instruction = instr_q;
    assign nextPC      = next_pc_q;
    assign PC          = pc_q;
    assign fetch_done  = done_q;
    assign busy        = (state_q == IF_WAIT);
    assign pc_err      = err_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_IF;
    logic        pc_update;
    logic [1:0]  PCsrc;
    logic [15:0] BTarget;
    logic [15:0] jumpTarget;
    logic [15:0] returnAddr;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ack;
    logic [15:0] instruction;
    logic [15:0] nextPC;
    logic [15:0] PC;
    logic        fetch_done;
    logic        busy;
    logic        pc_err;

    int total = 0;
    int bad   = 0;

    if_stage #(
        .DATA_W   (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable_IF   (enable_IF),
        .pc_update   (pc_update),
        .PCsrc       (PCsrc),
        .BTarget     (BTarget),
        .jumpTarget  (jumpTarget),
        .returnAddr  (returnAddr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .instruction (instruction),
        .nextPC      (nextPC),
        .PC          (PC),
        .fetch_done  (fetch_done),
        .busy        (busy),
        .pc_err      (pc_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs applied beforehand are sampled there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; enable_IF = 1'b0; pc_update = 1'b0; PCsrc = 2'b00;
        BTarget = '0; jumpTarget = '0; returnAddr = '0;
        imem_rdata = '0; imem_ack = 1'b0;
        step();
        step();
        chk("rst_pc", PC, 16'h0000);
        chk("rst_instr", instruction, 16'h0000);
        chk("rst_nextpc", nextPC, 16'h0000);
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_done", {15'd0, fetch_done}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_err", {15'd0, pc_err}, 16'd0);
        reset = 1'b0;
        step();

        // Fetch with two wait cycles.
        enable_IF = 1'b1;
        step();
        enable_IF = 1'b0;
        chk("t1_req_c1", {15'd0, imem_req}, 16'd1);
        chk("t1_busy_c1", {15'd0, busy}, 16'd1);
        chk("t1_addr_c1", imem_addr, 16'h0000);
        step();
        chk("t1_addr_c2", imem_addr, 16'h0000);
        chk("t1_done_c2", {15'd0, fetch_done}, 16'd0);
        step();
        chk("t1_addr_c3", imem_addr, 16'h0000);
        chk("t1_req_c3", {15'd0, imem_req}, 16'd1);
        imem_ack = 1'b1; imem_rdata = 16'hD963;
        step();
        imem_ack = 1'b0; imem_rdata = 16'h0000;
        chk("t1_instr", instruction, 16'hD963);
        chk("t1_nextpc", nextPC, 16'h0001);
        chk("t1_done", {15'd0, fetch_done}, 16'd1);
        chk("t1_req_drop", {15'd0, imem_req}, 16'd0);
        chk("t1_busy_drop", {15'd0, busy}, 16'd0);
        step();
        chk("t1_done_pulse", {15'd0, fetch_done}, 16'd0);
        chk("t1_pc_kept", PC, 16'h0000);

        // Stray ack while idle: ignored, no error.
        imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        step();
        imem_ack = 1'b0;
        chk("idle_ack_err", {15'd0, pc_err}, 16'd0);
        chk("idle_ack_instr", instruction, 16'hD963);
        chk("idle_ack_done", {15'd0, fetch_done}, 16'd0);

        // Branch load then fetch.
        pc_update = 1'b1; PCsrc = 2'b01; BTarget = 16'h0040;
        step();
        pc_update = 1'b0;
        chk("t2_pc", PC, 16'h0040);
        enable_IF = 1'b1;
        step();
        enable_IF = 1'b0;
        chk("t2_addr", imem_addr, 16'h0040);
        imem_ack = 1'b1; imem_rdata = 16'h631C;
        step();
        imem_ack = 1'b0;
        chk("t2_instr", instruction, 16'h631C);
        chk("t2_nextpc", nextPC, 16'h0041);
        step();

        // Jump load and fetch in the same idle cycle, zero-wait memory.
        pc_update = 1'b1; PCsrc = 2'b10; jumpTarget = 16'h0123; enable_IF = 1'b1;
        step();
        pc_update = 1'b0; enable_IF = 1'b0;
        chk("t3_addr", imem_addr, 16'h0123);
        chk("t3_pc", PC, 16'h0123);
        chk("t3_done_early", {15'd0, fetch_done}, 16'd0);
        imem_ack = 1'b1; imem_rdata = 16'h1234;
        step();
        imem_ack = 1'b0;
        chk("t3_done", {15'd0, fetch_done}, 16'd1);
        chk("t3_instr", instruction, 16'h1234);
        chk("t3_nextpc", nextPC, 16'h0124);
        step();

        // Return address select.
        pc_update = 1'b1; PCsrc = 2'b11; returnAddr = 16'h0777;
        step();
        pc_update = 1'b0;
        chk("ret_pc", PC, 16'h0777);

        // Wrap at FFFF.
        pc_update = 1'b1; PCsrc = 2'b10; jumpTarget = 16'hFFFF;
        step();
        pc_update = 1'b0;
        chk("t4_pc_ffff", PC, 16'hFFFF);
        enable_IF = 1'b1;
        step();
        enable_IF = 1'b0;
        chk("t4_addr", imem_addr, 16'hFFFF);
        imem_ack = 1'b1; imem_rdata = 16'hABCD;
        step();
        imem_ack = 1'b0;
        chk("t4_nextpc_wrap", nextPC, 16'h0000);
        pc_update = 1'b1; PCsrc = 2'b00;
        step();
        pc_update = 1'b0;
        chk("t4_pc_wrap", PC, 16'h0000);

        // Protocol errors during WAIT.
        enable_IF = 1'b1;
        step();
        enable_IF = 1'b0;
        chk("t5_err_before", {15'd0, pc_err}, 16'd0);
        pc_update = 1'b1; PCsrc = 2'b01; BTarget = 16'h0555; enable_IF = 1'b1;
        step();
        pc_update = 1'b0; enable_IF = 1'b0;
        chk("t5_pc_unchanged", PC, 16'h0000);
        chk("t5_err", {15'd0, pc_err}, 16'd1);
        chk("t5_addr_held", imem_addr, 16'h0000);
        chk("t5_req_held", {15'd0, imem_req}, 16'd1);
        imem_ack = 1'b1; imem_rdata = 16'h5A5A;
        step();
        imem_ack = 1'b0;
        chk("t5_instr", instruction, 16'h5A5A);
        step();
        step();
        chk("t5_no_second_req", {15'd0, imem_req}, 16'd0);
        chk("t5_err_sticky", {15'd0, pc_err}, 16'd1);

        // Reset asserted mid-WAIT.
        enable_IF = 1'b1;
        step();
        enable_IF = 1'b0;
        chk("t6_req_before", {15'd0, imem_req}, 16'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_req_async", {15'd0, imem_req}, 16'd0);
        chk("t6_busy_async", {15'd0, busy}, 16'd0);
        chk("t6_err_cleared", {15'd0, pc_err}, 16'd0);
        step();
        reset = 1'b0;
        step();
        imem_ack = 1'b1; imem_rdata = 16'h9999;
        step();
        imem_ack = 1'b0;
        chk("t6_instr", instruction, 16'h0000);
        chk("t6_done", {15'd0, fetch_done}, 16'd0);
        chk("t6_req", {15'd0, imem_req}, 16'd0);
        chk("t6_nextpc", nextPC, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
